// File: rtl/elevator_shaft_model.sv
// Plant emulator for the three-floor freight lift: integrates the motor command into a
// cabin step position at a prescaled rate and decodes the FC1..FC3 floor limit switches.
// Latches sticky flags for overtravel, direct reversal and the illegal 11 motor code.
module elevator_shaft_model #(
  parameter int  TICK_DIV    = 400000,
  parameter int  FLOOR_GAP   = 20,
  parameter int  START_FLOOR = 0,
  localparam int POS_W       = $clog2(2*FLOOR_GAP+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       motor,
  input  logic             fault_clr,
  output logic             FC1,
  output logic             FC2,
  output logic             FC3,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       moving,
  output logic             fault_ovt,
  output logic             fault_rev,
  output logic             fault_ill
);

  localparam int PW = $clog2(TICK_DIV);

  // State codes double as the moving encoding, so moving is the state register itself.
  localparam logic [1:0] ST_STOP = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DOWN = 2'b10;

  localparam logic [1:0] MOT_UP   = 2'b01;
  localparam logic [1:0] MOT_DOWN = 2'b10;
  localparam logic [1:0] MOT_ILL  = 2'b11;

  localparam logic [POS_W-1:0] TOP_POS    = POS_W'(2*FLOOR_GAP);
  localparam logic [POS_W-1:0] MID_POS    = POS_W'(FLOOR_GAP);
  localparam logic [POS_W-1:0] START_POS  = POS_W'(START_FLOOR*FLOOR_GAP);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV-1);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             fc1_q, fc2_q, fc3_q;
  logic             ovt_q, ovt_d;
  logic             rev_q, rev_d;
  logic             ill_q, ill_d;

  logic rev_hit, ill_hit, ovt_hit;
  logic wrap, step_up, step_dn;

  // Next plant state: a direct reversal is forced through one STOP cycle before the new direction.
  always_comb begin
    state_d = ST_STOP;
    rev_hit = 1'b0;
    if ((state_q == ST_UP && motor == MOT_DOWN) || (state_q == ST_DOWN && motor == MOT_UP)) begin
      rev_hit = 1'b1;
      state_d = ST_STOP;
    end else if (motor == MOT_UP) begin
      state_d = ST_UP;
    end else if (motor == MOT_DOWN) begin
      state_d = ST_DOWN;
    end
  end

  // Prescaler and position step; a step at either shaft end is swallowed and flagged instead.
  always_comb begin
    ill_hit = (motor == MOT_ILL);
    wrap    = (state_q != ST_STOP) && (presc_q == PRESC_LAST);
    step_up = wrap && (state_q == ST_UP);
    step_dn = wrap && (state_q == ST_DOWN);
    ovt_hit = (step_up && pos_q == TOP_POS) || (step_dn && pos_q == '0);

    if (state_q == ST_STOP || state_d != state_q || wrap) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    pos_d = pos_q;
    if (step_up && pos_q != TOP_POS) begin
      pos_d = pos_q + 1'b1;
    end else if (step_dn && pos_q != '0) begin
      pos_d = pos_q - 1'b1;
    end

    // A new fault in the same cycle as fault_clr keeps the flag set.
    ovt_d = ovt_hit | (ovt_q & ~fault_clr);
    rev_d = rev_hit | (rev_q & ~fault_clr);
    ill_d = ill_hit | (ill_q & ~fault_clr);
  end

  // Plant registers; reset snaps the cabin back to the start floor (no retained position).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      pos_q   <= START_POS;
      fc1_q   <= (START_POS == '0);
      fc2_q   <= (START_POS == MID_POS);
      fc3_q   <= (START_POS == TOP_POS);
      ovt_q   <= 1'b0;
      rev_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
      // Switches decode the registered position, so they trail pos by one cycle.
      fc1_q   <= (pos_q == '0);
      fc2_q   <= (pos_q == MID_POS);
      fc3_q   <= (pos_q == TOP_POS);
      ovt_q   <= ovt_d;
      rev_q   <= rev_d;
      ill_q   <= ill_d;
    end
  end

  assign FC1       = fc1_q;
  assign FC2       = fc2_q;
  assign FC3       = fc3_q;
  assign pos       = pos_q;
  assign moving    = state_q;
  assign fault_ovt = ovt_q;
  assign fault_rev = rev_q;
  assign fault_ill = ill_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Bench for elevator_shaft_model with TICK_DIV=4, FLOOR_GAP=3; a second instance uses START_FLOOR=2.
// Position steps are predicted as (cycle, pos) entries when the motor command is driven and
// popped by a negedge monitor whenever the DUT pos changes.
module tb_elevator_shaft_model;

  logic       clk;
  logic       rst_n;
  logic [1:0] motor;
  logic       fault_clr;
  logic       fc1, fc2, fc3;
  logic [2:0] pos;
  logic [1:0] moving;
  logic       f_ovt, f_rev, f_ill;

  logic [1:0] motor_b;
  logic       fault_clr_b;
  logic       fc1_b, fc2_b, fc3_b;
  logic [2:0] pos_b;
  logic [1:0] moving_b;
  logic       f_ovt_b, f_rev_b, f_ill_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int   exp_cyc[$];
  int   exp_pos[$];
  logic sb_en = 1'b0;
  logic [2:0] pos_prev;
  int   sb_c, sb_p;

  elevator_shaft_model #(.TICK_DIV(4), .FLOOR_GAP(3), .START_FLOOR(0)) dut (
    .clk(clk), .reset(rst_n), .motor(motor), .fault_clr(fault_clr),
    .FC1(fc1), .FC2(fc2), .FC3(fc3), .pos(pos), .moving(moving),
    .fault_ovt(f_ovt), .fault_rev(f_rev), .fault_ill(f_ill)
  );

  elevator_shaft_model #(.TICK_DIV(4), .FLOOR_GAP(3), .START_FLOOR(2)) dut_top (
    .clk(clk), .reset(rst_n), .motor(motor_b), .fault_clr(fault_clr_b),
    .FC1(fc1_b), .FC2(fc2_b), .FC3(fc3_b), .pos(pos_b), .moving(moving_b),
    .fault_ovt(f_ovt_b), .fault_rev(f_rev_b), .fault_ill(f_ill_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter: at a negedge, cyc is the number of rising edges seen so far.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard monitor: every pos change must match the next predicted (cycle, pos) entry.
  initial begin
    pos_prev = 3'd0;
    forever begin
      @(negedge clk);
      if (sb_en && pos !== pos_prev) begin
        total++;
        if (exp_pos.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_step: pos=%0d at cycle %0d, no step predicted", pos, cyc);
        end else begin
          sb_p = exp_pos.pop_front();
          sb_c = exp_cyc.pop_front();
          if (pos !== 3'(sb_p) || cyc != sb_c) begin
            bad++;
            $display("FAIL sb_step: got pos=%0d at cycle %0d, want pos=%0d at cycle %0d",
                     pos, cyc, sb_p, sb_c);
          end
        end
      end
      pos_prev = pos;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; motor = 2'b00; fault_clr = 1'b0;
    motor_b = 2'b00; fault_clr_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({fc1, fc2, fc3} !== 3'b100 || pos !== 3'd0 || moving !== 2'b00 ||
        {f_ovt, f_rev, f_ill} !== 3'b000) begin
      bad++;
      $display("FAIL reset_state: fc=%b pos=%0d moving=%b faults=%b, want fc=100 pos=0 moving=00 faults=000",
               {fc1, fc2, fc3}, pos, moving, {f_ovt, f_rev, f_ill});
    end
    sb_en = 1'b1;
  endtask

  task automatic test_up_one_floor;
    int c0;
    c0 = cyc;
    motor = 2'b01;
    exp_cyc.push_back(c0 + 5);  exp_pos.push_back(1);
    exp_cyc.push_back(c0 + 9);  exp_pos.push_back(2);
    exp_cyc.push_back(c0 + 13); exp_pos.push_back(3);
    repeat (5) @(negedge clk);
    total++;
    if (fc1 !== 1'b1) begin
      bad++; $display("FAIL t2_fc1_lag: FC1=%b at first step cycle, want 1", fc1);
    end
    @(negedge clk);
    total++;
    if (fc1 !== 1'b0 || moving !== 2'b01) begin
      bad++; $display("FAIL t2_fc1_drop: FC1=%b moving=%b, want 0 01", fc1, moving);
    end
    repeat (7) @(negedge clk);
    total++;
    if (fc2 !== 1'b0) begin
      bad++; $display("FAIL t2_fc2_lag: FC2=%b on the cycle pos reaches 3, want 0", fc2);
    end
    @(negedge clk);
    total++;
    if (fc2 !== 1'b1) begin
      bad++; $display("FAIL t2_fc2_rise: FC2=%b, want 1", fc2);
    end
    motor = 2'b00;
    @(negedge clk);
    total++;
    if (moving !== 2'b00) begin
      bad++; $display("FAIL t2_stop: moving=%b, want 00", moving);
    end
    repeat (8) @(negedge clk);
    total++;
    if (pos !== 3'd3 || exp_pos.size() != 0) begin
      bad++; $display("FAIL t2_hold: pos=%0d pending=%0d, want pos=3 pending=0", pos, exp_pos.size());
    end
  endtask

  task automatic test_overtravel;
    int c0;
    c0 = cyc;
    motor = 2'b01;
    exp_cyc.push_back(c0 + 5);  exp_pos.push_back(4);
    exp_cyc.push_back(c0 + 9);  exp_pos.push_back(5);
    exp_cyc.push_back(c0 + 13); exp_pos.push_back(6);
    repeat (16) @(negedge clk);
    total++;
    if (f_ovt !== 1'b0 || fc3 !== 1'b1) begin
      bad++; $display("FAIL t3_pre_ovt: fault_ovt=%b FC3=%b, want 0 1", f_ovt, fc3);
    end
    @(negedge clk);
    total++;
    if (f_ovt !== 1'b1 || pos !== 3'd6) begin
      bad++; $display("FAIL t3_ovt_set: fault_ovt=%b pos=%0d, want 1 6", f_ovt, pos);
    end
    repeat (3) @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    total++;
    if (f_ovt !== 1'b1) begin
      bad++; $display("FAIL t3_set_wins: fault_ovt=%b with clear and overtravel together, want 1", f_ovt);
    end
    motor = 2'b00;
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (f_ovt !== 1'b0 || fc3 !== 1'b1 || pos !== 3'd6 || moving !== 2'b00 || exp_pos.size() != 0) begin
      bad++; $display("FAIL t3_clear: fault_ovt=%b FC3=%b pos=%0d moving=%b pending=%0d, want 0 1 6 00 0",
                      f_ovt, fc3, pos, moving, exp_pos.size());
    end
  endtask

  task automatic test_reversal;
    int c0;
    c0 = cyc;
    motor = 2'b10;
    exp_cyc.push_back(c0 + 5);  exp_pos.push_back(5);
    exp_cyc.push_back(c0 + 11); exp_pos.push_back(6);
    repeat (5) @(negedge clk);
    motor = 2'b01;
    @(negedge clk);
    total++;
    if (f_rev !== 1'b1 || moving !== 2'b00) begin
      bad++; $display("FAIL t4_rev_stop: fault_rev=%b moving=%b, want 1 00", f_rev, moving);
    end
    @(negedge clk);
    total++;
    if (moving !== 2'b01) begin
      bad++; $display("FAIL t4_reenter_up: moving=%b, want 01", moving);
    end
    repeat (3) @(negedge clk);
    total++;
    if (pos !== 3'd5) begin
      bad++; $display("FAIL t4_no_early_step: pos=%0d, want 5", pos);
    end
    @(negedge clk);
    motor = 2'b00;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (f_rev !== 1'b0 || pos !== 3'd6 || moving !== 2'b00 || exp_pos.size() != 0) begin
      bad++; $display("FAIL t4_clear: fault_rev=%b pos=%0d moving=%b pending=%0d, want 0 6 00 0",
                      f_rev, pos, moving, exp_pos.size());
    end
  endtask

  task automatic test_illegal;
    int c0;
    c0 = cyc;
    motor = 2'b10;
    exp_cyc.push_back(c0 + 5);  exp_pos.push_back(5);
    exp_cyc.push_back(c0 + 9);  exp_pos.push_back(4);
    exp_cyc.push_back(c0 + 13); exp_pos.push_back(3);
    repeat (13) @(negedge clk);
    motor = 2'b00;
    @(negedge clk);
    total++;
    if (fc2 !== 1'b1 || f_ill !== 1'b0) begin
      bad++; $display("FAIL t5_at_floor2: FC2=%b fault_ill=%b, want 1 0", fc2, f_ill);
    end
    motor = 2'b11;
    @(negedge clk);
    total++;
    if (f_ill !== 1'b1 || moving !== 2'b00) begin
      bad++; $display("FAIL t5_ill_set: fault_ill=%b moving=%b, want 1 00", f_ill, moving);
    end
    repeat (9) @(negedge clk);
    total++;
    if (pos !== 3'd3 || moving !== 2'b00 || fc2 !== 1'b1 || f_ill !== 1'b1) begin
      bad++; $display("FAIL t5_ill_hold: pos=%0d moving=%b FC2=%b fault_ill=%b, want 3 00 1 1",
                      pos, moving, fc2, f_ill);
    end
    motor = 2'b00;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    total++;
    if (f_ill !== 1'b0 || exp_pos.size() != 0) begin
      bad++; $display("FAIL t5_clear: fault_ill=%b pending=%0d, want 0 0", f_ill, exp_pos.size());
    end
  endtask

  task automatic test_reset_mid_travel;
    int c0;
    motor = 2'b11;
    @(negedge clk);
    c0 = cyc;
    motor = 2'b10;
    exp_cyc.push_back(c0 + 5); exp_pos.push_back(2);
    total++;
    if (f_ill !== 1'b1) begin
      bad++; $display("FAIL t6_fault_before: fault_ill=%b, want 1", f_ill);
    end
    repeat (7) @(negedge clk);
    total++;
    if (pos !== 3'd2 || moving !== 2'b10 || exp_pos.size() != 0) begin
      bad++; $display("FAIL t6_mid_travel: pos=%0d moving=%b pending=%0d, want 2 10 0", pos, moving, exp_pos.size());
    end
    sb_en = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (pos !== 3'd0 || {fc1, fc2, fc3} !== 3'b100 || moving !== 2'b00 ||
        {f_ovt, f_rev, f_ill} !== 3'b000) begin
      bad++; $display("FAIL t6_async_reset: pos=%0d fc=%b moving=%b faults=%b, want 0 100 00 000",
                      pos, {fc1, fc2, fc3}, moving, {f_ovt, f_rev, f_ill});
    end
    total++;
    if (pos_b !== 3'd6 || {fc1_b, fc2_b, fc3_b} !== 3'b001 || moving_b !== 2'b00 ||
        {f_ovt_b, f_rev_b, f_ill_b} !== 3'b000) begin
      bad++; $display("FAIL t6_start_floor3: pos=%0d fc=%b moving=%b faults=%b, want 6 001 00 000",
                      pos_b, {fc1_b, fc2_b, fc3_b}, moving_b, {f_ovt_b, f_rev_b, f_ill_b});
    end
    motor = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sb_en = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (pos !== 3'd0 || fc1 !== 1'b1 || pos_b !== 3'd6 || fc3_b !== 1'b1) begin
      bad++; $display("FAIL t6_after_release: pos=%0d FC1=%b top_pos=%0d top_FC3=%b, want 0 1 6 1",
                      pos, fc1, pos_b, fc3_b);
    end
  endtask

  initial begin
    test_reset();
    test_up_one_floor();
    test_overtravel();
    test_reversal();
    test_illegal();
    test_reset_mid_travel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elevator_shaft_model.md
Name: elevator_shaft_model

Overview:
- Synthesizable plant emulator for the three-floor freight elevator: it consumes the controller's motor command and produces the floor limit switches FC1..FC3.
- It is the plant-side counterpart to the lift controller, and closes the loop in simulation and on the board (hardware-in-the-loop) in place of hand-driven FC stimulus.
- It models cabin position as a step counter advanced at a fixed prescaled rate, and flags physically impossible commands.

Parameters:
- TICK_DIV, 400000: clk cycles per one position step (0.1 s at the 4 MHz system clock); minimum 2.
- FLOOR_GAP, 20: position steps between adjacent floors; minimum 2.
- START_FLOOR, 0: floor index at reset (0 = floor 1, 1 = floor 2, 2 = floor 3).

Ports:
- clk  in  1  system clock (4 MHz).
- reset  in  1  asynchronous reset, active-low; one clock domain throughout.
- motor  in  2  controller command: 00 stop, 01 up, 10 down, 11 illegal.
- fault_clr  in  1  synchronous pulse that clears the sticky fault flags.
- FC1  out  1  limit switch, cabin at floor 1 (pos == 0).
- FC2  out  1  limit switch, cabin at floor 2 (pos == FLOOR_GAP).
- FC3  out  1  limit switch, cabin at floor 3 (pos == 2*FLOOR_GAP).
- pos  out  POS_W  cabin position in steps, where POS_W = clog2(2*FLOOR_GAP+1).
- moving  out  2  plant state: 00 stopped, 01 rising, 10 falling.
- fault_ovt  out  1  sticky flag: overtravel attempted past the top or bottom of the shaft.
- fault_rev  out  1  sticky flag: direct reversal (01 to 10 or 10 to 01) without a stop cycle.
- fault_ill  out  1  sticky flag: motor == 11 was seen.

Behaviour:
- Reset (reset low, asynchronous):
  - pos = START_FLOOR*FLOOR_GAP; prescaler = 0; state STOP; moving = 00; all faults = 0.
  - FCx = 1 only for the start floor, the others 0.
- States are STOP, UP and DOWN, each evaluated per clk:
  - motor 01 goes to UP; motor 10 goes to DOWN; motor 00 or 11 goes to STOP.
  - The state register updates one cycle after motor changes. moving mirrors the state register.
- Direct reversal (UP with motor 10, or DOWN with motor 01):
  - set fault_rev and go to STOP for exactly one cycle, clearing the prescaler.
  - Then enter the new direction if the command persists.
- motor == 11: set fault_ill and treat as stop.
- Prescaler:
  - Counts only in UP or DOWN. It clears on entry to STOP and on any state change.
  - When it reaches TICK_DIV-1 it wraps to 0 and issues one step: pos+1 in UP, pos-1 in DOWN.
  - The first step occurs TICK_DIV cycles after entering UP or DOWN.
- Shaft limits:
  - A step in UP with pos == 2*FLOOR_GAP is suppressed; pos holds and fault_ovt is set.
  - A step in DOWN with pos == 0 is suppressed; pos holds and fault_ovt is set.
  - pos never leaves 0..2*FLOOR_GAP.
- Limit switches:
  - FC1..FC3 are registered decodes of pos, updating one cycle after pos.
  - At most one FC is high. All are low between floors.
- Faults:
  - Sticky until fault_clr is sampled high.
  - If fault_clr and a new fault condition occur in the same cycle, set wins.
  - fault_clr has no effect on pos or state.
- Reset asserted mid-travel: immediate return to reset values; pos snaps to the start floor (intentional, the model has no retained position).

Test Plan:
- T1, TICK_DIV=4, FLOOR_GAP=3, START_FLOOR=0: release reset -> FC1=1, pos=0, moving=00, all faults 0.
- T2, same parameters: motor=01 held -> pos increments every 4 cycles; FC1 drops one cycle after pos=1; FC2=1 one cycle after pos=3; stop at FC2 -> pos holds at 3, moving=00.
- T3, from pos=3: motor=01 until pos=6 (FC3=1), keep 01 for 8 more cycles -> pos stays 6, fault_ovt=1; pulse fault_clr with motor=00 -> fault_ovt=0, FC3 stays 1.
- T4, from pos=6: motor=10 for 5 cycles, then switch directly to 01 -> fault_rev=1, one STOP cycle (moving=00), prescaler restarts; next step occurs 4 cycles after UP re-entry.
- T5: motor=11 for 10 cycles at pos=3 -> pos unchanged, moving=00, fault_ill=1, FC2 stays 1.
- T6: motor=10 from pos=3; at pos=2 assert reset low mid-count -> immediately pos=0, FC1=1, moving=00, all faults 0; with START_FLOOR=2, pos=6 and FC3=1 at reset.
